// File: rtl/morse_pkg.sv
// Shared definitions for the Morse digit sequencer.
// Holds the FSM state encoding, the symbol polarity in the codifier pattern,
// the length of each keying phase in Morse units, and the highest digit the
// sequencer accepts.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_MARK    = 3'd3,
    ST_SPACE   = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Polarity of one symbol bit in the codifier pattern.
  localparam logic DOT  = 1'b1;
  localparam logic DASH = 1'b0;

  localparam int unsigned DOT_UNITS   = 1;
  localparam int unsigned DASH_UNITS  = 3;
  localparam int unsigned SPACE_UNITS = 1;
  localparam int unsigned GAP_UNITS   = 3;

  localparam logic [3:0]  MAX_DIGIT   = 4'd9;
  localparam int unsigned NUM_SYMBOLS = 5;

  // Length of the key-down phase for one symbol, in Morse units.
  function automatic int unsigned mark_units(input logic sym);
    return (sym == DASH) ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter that times one keying phase.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   load         - load load_val this cycle (takes priority over counting)
//   load_val     - phase length minus one, in clock cycles
//   tc           - terminal count: counter is at zero
// The counter parks at zero rather than wrapping, so tc stays high in idle.
module morse_unit_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/morse_sequencer.sv
// Keys one decimal digit out as Morse code on tx_out.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   num, req    - digit and request, sampled every cycle while idle
//   ack, err    - one-cycle pulses: request accepted / rejected (num > 9)
//   busy        - high while a digit is in flight
//   done        - one-cycle pulse when the inter-digit gap finishes
//   tx_out      - keyed output, 1 = tone on
//   cod_num, cod_ready, cod_morse - handshake with the external codifier;
//                 cod_morse bit 0 is the first symbol, 1 = dot, 0 = dash
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req; rejects digits above 9
// LOAD     | strobe cod_ready with the latched digit
// CAPTURE  | register the codifier pattern, start the first mark
// MARK     | key down for 1 (dot) or 3 (dash) units
// SPACE    | key up 1 unit between symbols
// GAP      | key up 3 units after the fifth symbol, then done
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       req,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic       done,
  output logic       tx_out,
  output logic [3:0] cod_num,
  output logic       cod_ready,
  input  logic [4:0] cod_morse
);

  localparam int unsigned CNT_W    = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [2:0]  LAST_IDX = 3'(NUM_SYMBOLS - 1);

  state_t           state;
  logic [4:0]       pattern;
  logic [2:0]       idx;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tc;

  // Timer reload value for a phase lasting the given number of units.
  function automatic logic [CNT_W-1:0] phase_val(input int unsigned units);
    return CNT_W'(units * UNIT_CYCLES - 1);
  endfunction

  morse_unit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // The timer is reloaded on the same edge the FSM enters a new phase, so
  // every phase lasts exactly its unit count times UNIT_CYCLES.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_CAPTURE: begin
        // Pattern register is written on this same edge; use the live input.
        tmr_load = 1'b1;
        tmr_val  = phase_val(mark_units(cod_morse[0]));
      end
      ST_MARK: begin
        tmr_load = tc;
        tmr_val  = (idx == LAST_IDX) ? phase_val(GAP_UNITS) : phase_val(SPACE_UNITS);
      end
      ST_SPACE: begin
        // idx already points at the next symbol.
        tmr_load = tc;
        tmr_val  = phase_val(mark_units(pattern[idx]));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_out    <= 1'b0;
      cod_num   <= 4'd0;
      cod_ready <= 1'b0;
      pattern   <= 5'd0;
      idx       <= 3'd0;
    end else begin
      ack       <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      cod_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            if (num <= MAX_DIGIT) begin
              cod_num   <= num;
              ack       <= 1'b1;
              busy      <= 1'b1;
              cod_ready <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          pattern <= cod_morse;
          idx     <= 3'd0;
          tx_out  <= 1'b1;
          state   <= ST_MARK;
        end
        ST_MARK: begin
          if (tc) begin
            tx_out <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= ST_GAP;
            end else begin
              idx   <= idx + 3'd1;
              state <= ST_SPACE;
            end
          end
        end
        ST_SPACE: begin
          if (tc) begin
            tx_out <= 1'b1;
            state  <= ST_MARK;
          end
        end
        ST_GAP: begin
          if (tc) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer. The reference model turns each accepted request
// into the full expected per-cycle output waveform (queued), built from the
// Morse timing rules; every cycle the DUT outputs are compared with the head
// of that queue (or the idle vector when nothing is in flight).
module tb_morse_sequencer;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [3:0] num;
  logic       ack, err, busy, done, tx_out, cod_ready;
  logic [3:0] cod_num;
  logic [4:0] cod_morse = 5'd0;

  always #5 clk = ~clk;

  morse_sequencer #(.UNIT_CYCLES(U)) dut (
    .clk       (clk),
    .reset     (reset),
    .num       (num),
    .req       (req),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .done      (done),
    .tx_out    (tx_out),
    .cod_num   (cod_num),
    .cod_ready (cod_ready),
    .cod_morse (cod_morse)
  );

  // Standard Morse digit table: bit i is symbol i, 1 = dot.
  function automatic logic [4:0] morse_code(input int d);
    logic [4:0] p;
    p = 5'd0;
    for (int i = 0; i < 5; i++) begin
      if (d >= 1 && d <= 5)      p[i] = (i < d);
      else if (d >= 6 && d <= 9) p[i] = (i >= d - 5);
      else                       p[i] = 1'b0;
    end
    return p;
  endfunction

  // Codifier model: answers the strobe on the following cycle.
  always @(posedge clk) if (cod_ready) cod_morse <= morse_code(int'(cod_num));

  typedef struct packed {
    logic       ack;
    logic       err;
    logic       busy;
    logic       done;
    logic       tx;
    logic       rdy;
    logic [3:0] cnum;
  } vec_t;

  vec_t       exp_q[$];
  logic [3:0] last_cod_num;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic e, input logic b, input logic d,
                              input logic t, input logic r, input logic [3:0] c);
    vec_t v;
    v.ack = a; v.err = e; v.busy = b; v.done = d; v.tx = t; v.rdy = r; v.cnum = c;
    return v;
  endfunction

  // Queue the whole waveform of one accepted digit, starting the cycle after
  // the sampling edge.
  task automatic push_digit(input int d);
    logic [4:0]  p;
    int unsigned len;
    logic [3:0]  c;
    p = morse_code(d);
    c = 4'(d);
    exp_q.push_back(mk(1, 0, 1, 0, 0, 1, c));
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, c));
    for (int i = 0; i < 5; i++) begin
      len = (p[i] ? 1 : 3) * U;
      for (int k = 0; k < int'(len); k++) exp_q.push_back(mk(0, 0, 1, 0, 1, 0, c));
      len = (i < 4 ? 1 : 3) * U;
      for (int k = 0; k < int'(len); k++) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, c));
    end
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, c));
  endtask

  // Compare this cycle, then present the next inputs and advance the model.
  task automatic step(input logic r, input logic [3:0] n, input logic rq);
    vec_t e;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = mk(0, 0, 0, 0, 0, 0, last_cod_num);
    last_cod_num = e.cnum;
    check_eq("ack",       8'(ack),       8'(e.ack));
    check_eq("err",       8'(err),       8'(e.err));
    check_eq("busy",      8'(busy),      8'(e.busy));
    check_eq("done",      8'(done),      8'(e.done));
    check_eq("tx_out",    8'(tx_out),    8'(e.tx));
    check_eq("cod_ready", 8'(cod_ready), 8'(e.rdy));
    check_eq("cod_num",   8'(cod_num),   8'(e.cnum));
    reset = r;
    num   = n;
    req   = rq;
    if (r) begin
      exp_q.delete();
      last_cod_num = 4'd0;
    end else if (rq && exp_q.size() == 0) begin
      if (n <= 4'd9) push_digit(int'(n));
      else           exp_q.push_back(mk(0, 1, 0, 0, 0, 0, last_cod_num));
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 4'd0, 0);
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    num   = 4'd0;
    last_cod_num = 4'd0;
    repeat (2) @(posedge clk);
    step(1, 4'd0, 0);
    idle(2);

    step(0, 4'd5, 1);              // all dots
    idle(55);
    step(0, 4'd0, 1);              // all dashes
    idle(95);
    step(0, 4'd12, 1);             // rejected digit
    idle(5);
    step(0, 4'd15, 1);
    idle(3);

    step(0, 4'd1, 1);              // request ignored mid-mark
    idle(10);
    for (int i = 0; i < 3; i++) step(0, 4'd7, 1);
    idle(85);

    step(0, 4'd3, 1);              // reset in third symbol
    idle(19);
    step(1, 4'd0, 0);
    step(0, 4'd9, 1);
    idle(95);

    step(1, 4'd4, 1);              // reset beats req
    idle(5);

    for (int i = 0; i < 230; i++) step(0, 4'd2, 1);  // back-to-back
    idle(80);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0);
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 4, meaning clock cycles per Morse time unit (legal values 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port num  input  4  digit to transmit, sampled with req.
REQ-005 SHALL have port req  input  1  transmit request, level-sampled each cycle.
REQ-006 SHALL have port ack  output  1  one-cycle pulse: request accepted.
REQ-007 SHALL have port err  output  1  one-cycle pulse: request rejected (num > 9).
REQ-008 SHALL have port busy  output  1  high while a digit is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse: digit transmission complete.
REQ-010 SHALL have port tx_out  output  1  keyed Morse output, 1 = tone/LED on.
REQ-011 SHALL have port cod_num  output  4  digit driven to the Morse codifier.
REQ-012 SHALL have port cod_ready  output  1  one-cycle strobe to the codifier.
REQ-013 SHALL have port cod_morse  input  5  codifier pattern; bit 1 = dot, bit 0 = dash; bit 0 sent first.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CAPTURE, MARK, SPACE, GAP.
REQ-015 IDLE: req=1 and num<=9 SHALL latch num, go to LOAD, pulse ack next cycle.
REQ-016 IDLE: req=1 and num>9 SHALL stay in IDLE, pulse err next cycle; no codifier strobe.
REQ-017 req while busy=1 SHALL be ignored: no ack, no err, latched digit unchanged.
REQ-018 LOAD (1 cycle): cod_ready=1, cod_num=latched digit; then CAPTURE.
REQ-019 CAPTURE (1 cycle): SHALL register cod_morse into a 5-bit pattern; symbol index=0; then MARK.
REQ-020 MARK: tx_out=1 for 1 unit (dot) or 3 units (dash) = UNIT_CYCLES or 3*UNIT_CYCLES cycles.
REQ-021 After MARK for symbol index 0..3: SPACE, tx_out=0 for 1 unit, index+1, back to MARK.
REQ-022 After MARK for symbol index 4: GAP, tx_out=0 for 3 units, then IDLE.
REQ-023 On GAP exit: done=1 for exactly one cycle, busy=0 in that cycle, and a req in that cycle SHALL be accepted.
REQ-024 busy SHALL be 1 from LOAD through last GAP cycle inclusive, 0 otherwise.
REQ-025 tx_out SHALL be 0 in IDLE, LOAD, CAPTURE, SPACE, GAP; first tx_out=1 cycle is 3 cycles after the req-sampling edge.
REQ-026 Unit counter SHALL be $clog2(3*UNIT_CYCLES+1) bits, reload on each phase entry, no wrap past terminal count.
REQ-027 cod_ready SHALL be 0 outside LOAD; cod_num SHALL hold the latched digit.
REQ-028 Total tx time per digit = (sum of mark units + 4 + 3) * UNIT_CYCLES cycles.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE regardless of state, including mid-MARK.
REQ-030 Reset values: ack=0, err=0, busy=0, done=0, tx_out=0, cod_ready=0, cod_num=0, pattern=0, counters=0.
REQ-031 reset SHALL take priority over req in the same cycle; no ack after reset release without a new req.

Structure
REQ-032 Package morse_pkg SHALL hold state encoding, DOT=1/DASH=0, DOT_UNITS=1, DASH_UNITS=3, SPACE_UNITS=1, GAP_UNITS=3, MAX_DIGIT=9.
REQ-033 One sub-module morse_unit_timer (loadable down-counter, terminal-count flag) SHALL be used; the codifier remains external.

Verification (UNIT_CYCLES=4, bench models the codifier)
REQ-034 num=5 (pattern 11111), req 1 cycle -> ack, five 4-cycle marks with 4-cycle spaces, 12-cycle gap, done; 48 tx cycles.
REQ-035 num=0 (pattern 00000) -> five 12-cycle marks, 88 tx cycles, done once, busy low with done.
REQ-036 num=12 -> err pulse one cycle, no ack, cod_ready never high, busy stays 0.
REQ-037 num=1 accepted, then req with num=7 mid-MARK -> ignored; tx sequence matches digit 1 (80 cycles).
REQ-038 reset asserted during third symbol of num=3 -> next cycle tx_out=0, busy=0, state IDLE; new req num=9 then transmits correctly.
REQ-039 req held high continuously with num=2 -> back-to-back transmissions, ack in cycle after each done.
